// File: rtl/updown_sweep_ctrl_pkg.sv
// Shared definitions for the up/down counter sweep sequencer: state encodings
// and counter direction values.
package updown_sweep_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    function automatic logic is_counting(input state_t s);
        return (s == ST_UP) || (s == ST_DOWN);
    endfunction

endpackage

// File: rtl/updown_sweep_ctrl_tracker.sv
// Shadow model of the counter: predicts q from the sequencer state and flags
// any cycle in which the real counter disagrees while a sweep is running.
module updown_sweep_ctrl_tracker
    import updown_sweep_ctrl_pkg::*;
#(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  state_t           state,
    input  logic [CNT_W-1:0] q,
    output logic             mismatch
);

    localparam logic [CNT_W-1:0] ONE = 1;

    logic [CNT_W-1:0] shadow;

    // Outside a sweep the counter is held cleared, so the shadow parks at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow <= '0;
        end else begin
            case (state)
                ST_UP:   shadow <= shadow + ONE;
                ST_DOWN: shadow <= shadow - ONE;
                default: shadow <= '0;
            endcase
        end
    end

    assign mismatch = is_counting(state) && (q != shadow);

endmodule

// File: rtl/updown_sweep_ctrl.sv
// Sequencer driving an external up/down counter through a requested number of
// triangle sweeps, with completion pulse, progress count and sticky fault flag.
module updown_sweep_ctrl
    import updown_sweep_ctrl_pkg::*;
#(
    parameter int CNT_W   = 2,
    parameter int SWEEP_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [SWEEP_W-1:0] n_sweeps,
    input  logic [CNT_W-1:0]   q,
    output logic               x,
    output logic               cnt_clr,
    output logic               busy,
    output logic               done,
    output logic [SWEEP_W-1:0] sweep_cnt,
    output logic               fault
);

    localparam logic [CNT_W-1:0]   Q_MAX  = '1;
    localparam logic [CNT_W-1:0]   Q_ONE  = 1;
    localparam logic [CNT_W-1:0]   Q_TURN = Q_MAX - Q_ONE;
    localparam logic [SWEEP_W-1:0] S_ONE  = 1;

    state_t             state;
    state_t             state_nxt;
    logic [SWEEP_W-1:0] n_latched;
    logic               mismatch;
    logic               accept;
    logic               sweep_end;

    updown_sweep_ctrl_tracker #(.CNT_W(CNT_W)) u_tracker (
        .clk      (clk),
        .reset    (reset),
        .state    (state),
        .q        (q),
        .mismatch (mismatch)
    );

    assign accept    = (state == ST_IDLE) && start && !abort;
    assign sweep_end = (state == ST_DOWN) && !abort && !mismatch && (q == Q_ONE);

    // Turn at MAX-1 so x is already DOWN on the cycle the counter reaches MAX.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) state_nxt = (n_sweeps == '0) ? ST_DONE : ST_UP;
            end
            ST_UP: begin
                if (abort || mismatch) state_nxt = ST_IDLE;
                else if (q == Q_TURN)  state_nxt = ST_DOWN;
            end
            ST_DOWN: begin
                if (abort || mismatch) state_nxt = ST_IDLE;
                else if (sweep_end)    state_nxt = (sweep_cnt + S_ONE == n_latched) ? ST_DONE : ST_UP;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        x       = DIR_UP;
        cnt_clr = 1'b1;
        busy    = 1'b0;
        done    = 1'b0;
        case (state)
            ST_UP: begin
                cnt_clr = 1'b0;
                busy    = 1'b1;
            end
            ST_DOWN: begin
                x       = DIR_DOWN;
                cnt_clr = 1'b0;
                busy    = 1'b1;
            end
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

    // Abort outranks fault capture; a zero-sweep request only clears the fault.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            n_latched <= '0;
            sweep_cnt <= '0;
            fault     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                fault <= 1'b0;
                if (n_sweeps != '0) begin
                    n_latched <= n_sweeps;
                    sweep_cnt <= '0;
                end
            end
            if (mismatch && !abort) fault <= 1'b1;
            if (sweep_end) sweep_cnt <= sweep_cnt + S_ONE;
        end
    end

endmodule
